// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: state encodings and default
// timing constants, also consumed by the bus-strobe scheduler.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_PHASES   = 4;
  localparam int DEF_PHASE_CYCLES = 3;
  localparam int DEF_GAP_CYCLES   = 1;
  localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between a sequencer controller (master) and the
// phase sequencer (slave).
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4
);
  logic                  run;
  logic                  step;
  logic                  step_ack;
  logic [NUM_PHASES-1:0] phase_en;
  logic                  cycle_done;
  logic                  busy;
  logic                  halted;

  modport master (
    output run, step,
    input  step_ack, phase_en, cycle_done, busy, halted
  );

  modport slave (
    input  run, step,
    output step_ack, phase_en, cycle_done, busy, halted
  );
endinterface

// File: rtl/phase_sequencer_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: load has priority, otherwise decrement until zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Non-overlapping phase-enable generator with free-run, halt and single-step;
// every output is registered so strobe drivers see glitch-free levels.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES   = DEF_NUM_PHASES,
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  phase_sequencer_if.slave  bus
);

  localparam int               PH_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] PH_LOAD  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam seq_state_e       LAST_ST  = HAS_GAP ? ST_GAP : ST_ACTIVE;

  seq_state_e            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  single_q, single_d;
  logic                  load_d;
  logic [CNT_W-1:0]      load_val_d;
  logic [CNT_W-1:0]      timer_cnt_s;
  logic                  timer_zero_s;
  logic                  adv_s;
  logic                  next_zero_s;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  step_ack_q, step_ack_d;
  logic                  cycle_done_q, cycle_done_d;
  logic                  busy_q, halted_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load_d),
    .load_val_i (load_val_d),
    .cnt_o      (timer_cnt_s),
    .zero_o     (timer_zero_s)
  );

  // A phase slot ends when its last timed segment (gap, or the enable itself
  // when gaps are disabled) has expired.
  assign adv_s = timer_zero_s &&
                 ((state_q == ST_GAP) || ((state_q == ST_ACTIVE) && !HAS_GAP));

  // Next-state logic: phase progression, cycle wrap and halt/step handling.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    single_d   = single_q;
    load_d     = 1'b0;
    load_val_d = PH_LOAD;
    step_ack_d = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (bus.run) begin
          state_d = ST_ACTIVE;
          phase_d = '0;
          load_d  = 1'b1;
        end else if (bus.step) begin
          state_d    = ST_ACTIVE;
          phase_d    = '0;
          load_d     = 1'b1;
          single_d   = 1'b1;
          step_ack_d = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_ACTIVE, ST_GAP: begin
        if (adv_s) begin
          if (phase_q != LAST_PH) begin
            state_d = ST_ACTIVE;
            phase_d = phase_q + PH_W'(1);
            load_d  = 1'b1;
          end else if (bus.run && !single_q) begin
            state_d = ST_ACTIVE;
            phase_d = '0;
            load_d  = 1'b1;
          end else begin
            state_d  = ST_HALT;
            phase_d  = '0;
            single_d = 1'b0;
          end
        end else if ((state_q == ST_ACTIVE) && timer_zero_s) begin
          state_d    = ST_GAP;
          load_d     = 1'b1;
          load_val_d = GAP_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_HALT;
        phase_d  = '0;
        single_d = 1'b0;
      end
    endcase
  end

  // The timer reads zero next clock if loaded with zero or currently at one.
  assign next_zero_s = load_d ? (load_val_d == '0) : (timer_cnt_s <= CNT_W'(1));

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    phase_en_d = '0;
    if (state_d == ST_ACTIVE) begin
      phase_en_d[phase_d] = 1'b1;
    end else begin
      phase_en_d = '0;
    end
    cycle_done_d = (state_d == LAST_ST) && (phase_d == LAST_PH) && next_zero_s;
  end

  // State and output registers; reset forces every enable low at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HALT;
      phase_q      <= '0;
      single_q     <= 1'b0;
      phase_en_q   <= '0;
      step_ack_q   <= 1'b0;
      cycle_done_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      single_q     <= single_d;
      phase_en_q   <= phase_en_d;
      step_ack_q   <= step_ack_d;
      cycle_done_q <= cycle_done_d;
      busy_q       <= (state_d != ST_HALT);
      halted_q     <= (state_d == ST_HALT);
    end
  end

  assign bus.phase_en   = phase_en_q;
  assign bus.step_ack   = step_ack_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: default-timing instance (a) and a gapless single-clock
// instance (b), both compared every clock against a cycle-position model.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(4)) bus_a ();
  phase_sequencer_if #(.NUM_PHASES(4)) bus_b ();

  phase_sequencer #(.NUM_PHASES(4), .PHASE_CYCLES(3), .GAP_CYCLES(1), .CNT_W(4))
    dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  phase_sequencer #(.NUM_PHASES(4), .PHASE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4))
    dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position within the machine cycle plus halted/single-shot flags.
  int         m_t[2];
  bit         m_halt[2];
  bit         m_single[2];
  bit         m_ack[2];
  int         mp[2] = '{3, 1};
  int         mg[2] = '{1, 0};
  logic [3:0] prev_pe[2];

  typedef struct {
    bit         run;
    bit         step;
    logic [3:0] pe;
    bit         cd;
    bit         busy;
  } vec_t;
  vec_t tv[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_halt[k] = 1'b1; m_single[k] = 1'b0; m_ack[k] = 1'b0;
      prev_pe[k] = 4'd0;
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit s);
    int len;
    len = 4 * (mp[k] + mg[k]);
    m_ack[k] = 1'b0;
    if (m_halt[k]) begin
      if (r) begin
        m_halt[k] = 1'b0; m_t[k] = 0;
      end else if (s) begin
        m_halt[k] = 1'b0; m_t[k] = 0; m_single[k] = 1'b1; m_ack[k] = 1'b1;
      end
    end else if (m_t[k] == len - 1) begin
      if (r && !m_single[k]) m_t[k] = 0;
      else begin
        m_halt[k] = 1'b1; m_single[k] = 1'b0; m_t[k] = 0;
      end
    end else begin
      m_t[k] = m_t[k] + 1;
    end
  endtask

  task automatic get_out(input int k, output logic [3:0] pe, output logic cd,
                         output logic bsy, output logic hlt, output logic ack);
    if (k == 0) begin
      pe = bus_a.phase_en; cd = bus_a.cycle_done; bsy = bus_a.busy;
      hlt = bus_a.halted; ack = bus_a.step_ack;
    end else begin
      pe = bus_b.phase_en; cd = bus_b.cycle_done; bsy = bus_b.busy;
      hlt = bus_b.halted; ack = bus_b.step_ack;
    end
  endtask

  task automatic check_model(input int k);
    logic [3:0] pe, exp_pe;
    logic       cd, bsy, hlt, ack;
    int         period, len;
    string      sfx;
    sfx    = (k == 0) ? "_a" : "_b";
    period = mp[k] + mg[k];
    len    = 4 * period;
    exp_pe = 4'd0;
    if (!m_halt[k] && ((m_t[k] % period) < mp[k])) exp_pe[m_t[k] / period] = 1'b1;
    get_out(k, pe, cd, bsy, hlt, ack);
    check({"phase_en", sfx}, pe, exp_pe);
    check({"cycle_done", sfx}, cd, !m_halt[k] && (m_t[k] == len - 1));
    check({"busy", sfx}, bsy, !m_halt[k]);
    check({"halted", sfx}, hlt, m_halt[k]);
    check({"step_ack", sfx}, ack, m_ack[k]);
    check({"onehot", sfx}, $countones(pe) > 1, 0);
    check({"busy_not_halted", sfx}, bsy, !hlt);
    if (k == 0) check("gap_between_phases_a", (prev_pe[k] != 0) && (pe != 0) && (pe != prev_pe[k]), 0);
    prev_pe[k] = pe;
  endtask

  task automatic cyc(input bit ra, input bit sa, input bit rb, input bit sb);
    bus_a.run = ra; bus_a.step = sa;
    bus_b.run = rb; bus_b.step = sb;
    @(posedge clk);
    model_step(0, ra, sa);
    model_step(1, rb, sb);
    @(negedge clk);
    check_model(0);
    check_model(1);
  endtask

  initial begin
    logic [3:0] pe_seq[18] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4,
                               4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    int  cnt, busy_cnt;
    bit  saw_p3;
    for (int i = 0; i < 18; i++) tv[i] = '{1'b1, 1'b0, pe_seq[i], (i == 15), 1'b1};

    bus_a.run = 1'b0; bus_a.step = 1'b0; bus_b.run = 1'b0; bus_b.step = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_model(0);
    check_model(1);
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Free run from halt: first cycle plus the seamless start of the next.
    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].run, tv[i].step, 0, 0);
      check("tbl_phase_en", bus_a.phase_en, tv[i].pe);
      check("tbl_cycle_done", bus_a.cycle_done, tv[i].cd);
      check("tbl_busy", bus_a.busy, tv[i].busy);
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      if (bus_a.cycle_done) cnt++;
    end
    check("drain_cycle_done_count", cnt, 1);
    check("drain_halted", bus_a.halted, 1);

    // Single step, with a second step mid-cycle that must be ignored.
    cyc(0, 1, 0, 0);
    check("step_ack_pulse", bus_a.step_ack, 1);
    check("step_first_phase", bus_a.phase_en, 4'h1);
    busy_cnt = 1; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, (i == 4), 0, 0);
      if (bus_a.busy) busy_cnt++;
      if (bus_a.step_ack) cnt++;
    end
    check("step_busy_clocks", busy_cnt, 16);
    check("step_extra_ack", cnt, 0);
    check("step_halted_after", bus_a.halted, 1);

    // Run dropped at clock 5: cycle still completes through phase 3.
    cnt = 0; saw_p3 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc(i < 5, 0, 0, 0);
      if (bus_a.cycle_done) cnt++;
      if (bus_a.phase_en == 4'h8) saw_p3 = 1'b1;
    end
    check("drop_cycle_done_count", cnt, 1);
    check("drop_reached_phase3", saw_p3, 1);
    check("drop_halted", bus_a.halted, 1);

    // Asynchronous reset during phase 2.
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
    check("pre_reset_phase2", bus_a.phase_en, 4'h4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_phase_en", bus_a.phase_en, 0);
    check("async_rst_busy", bus_a.busy, 0);
    check("async_rst_halted", bus_a.halted, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0);
    check("restart_phase0", bus_a.phase_en, 4'h1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);

    // Gapless single-clock phases on instance b.
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 0);
      check("b_phase_seq", bus_b.phase_en, 4'h1 << (i % 4));
      check("b_cycle_done", bus_b.cycle_done, (i % 4) == 3);
    end
    cyc(0, 0, 0, 0);
    check("b_halted", bus_b.halted, 1);

    // Randomized run/step traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 99) < 50), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
